// File: rtl/snax_mac_stream_pkg.sv
// Shared definitions for the SNAX MAC streaming accelerator.
// Holds the CSR address map, the operating mode and FSM state enums, the TCDM
// request/response structs and the default datapath widths.
package snax_mac_stream_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAccWidth  = 32;
    localparam int unsigned DefLenWidth  = 16;

    localparam int unsigned CsrPtrA   = 0;
    localparam int unsigned CsrPtrB   = 1;
    localparam int unsigned CsrPtrOut = 2;
    localparam int unsigned CsrLen    = 3;
    localparam int unsigned CsrMode   = 4;
    localparam int unsigned CsrInit   = 5;
    localparam int unsigned CsrCtrl   = 6;
    localparam int unsigned CsrStatus = 7;
    localparam int unsigned CsrResult = 8;

    typedef enum logic [1:0] {
        ModeDot     = 2'd0,
        ModeElem    = 2'd1,
        ModeDotInit = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRsp,
        StWr,
        StDone
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } tcdm_q_t;

    typedef struct packed {
        logic    q_valid;
        tcdm_q_t q;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] data;
    } tcdm_p_t;

    typedef struct packed {
        logic    q_ready;
        logic    p_valid;
        tcdm_p_t p;
    } tcdm_rsp_t;

endpackage

// File: rtl/snax_mac_stream_csr.sv
// CSR register file for snax_mac_stream.
// Ports: csr_req_* / csr_rsp_* valid/ready CSR port from the core; start_o pulses on an
// accepted CTRL start while idle; busy_o is the job-running flag; job_done_i ends a job;
// result_i is the accumulator read back via RESULT; ptr/len/mode/init outputs feed the FSM.
module snax_mac_stream_csr
    import snax_mac_stream_pkg::*;
#(
    parameter int unsigned CsrAddrWidth = 4,
    parameter int unsigned LenWidth     = DefLenWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CsrAddrWidth-1:0] csr_req_addr_i,
    input  logic [31:0]             csr_req_data_i,
    input  logic                    csr_req_write_i,
    input  logic                    csr_req_valid_i,
    output logic                    csr_req_ready_o,
    output logic [31:0]             csr_rsp_data_o,
    output logic                    csr_rsp_valid_o,
    input  logic                    csr_rsp_ready_i,
    input  logic                    job_done_i,
    input  logic [31:0]             result_i,
    output logic                    start_o,
    output logic                    busy_o,
    output logic [31:0]             ptr_a_o,
    output logic [31:0]             ptr_b_o,
    output logic [31:0]             ptr_out_o,
    output logic [LenWidth-1:0]     len_o,
    output logic [1:0]              mode_o,
    output logic [31:0]             init_o
);

    logic [31:0]         ptr_a_q, ptr_b_q, ptr_out_q, init_q;
    logic [LenWidth-1:0] len_q;
    logic [1:0]          mode_q;
    logic                busy_q, done_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic [31:0]         rdata;
    logic                req_fire, wr_fire;

    assign csr_req_ready_o = !rsp_valid_q;
    assign req_fire        = csr_req_valid_i && csr_req_ready_o;
    // Configuration is frozen while a job runs, CTRL included.
    assign wr_fire         = req_fire && csr_req_write_i && !busy_q;
    assign start_o         = wr_fire && (csr_req_addr_i == CsrAddrWidth'(CsrCtrl))
                             && csr_req_data_i[0];

    always_comb begin
        rdata = '0;
        case (csr_req_addr_i)
            CsrAddrWidth'(CsrPtrA):   rdata = ptr_a_q;
            CsrAddrWidth'(CsrPtrB):   rdata = ptr_b_q;
            CsrAddrWidth'(CsrPtrOut): rdata = ptr_out_q;
            CsrAddrWidth'(CsrLen):    rdata = 32'(len_q);
            CsrAddrWidth'(CsrMode):   rdata = {30'd0, mode_q};
            CsrAddrWidth'(CsrInit):   rdata = init_q;
            CsrAddrWidth'(CsrStatus): rdata = {30'd0, done_q, busy_q};
            CsrAddrWidth'(CsrResult): rdata = result_i;
            default:                  rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_a_q     <= '0;
            ptr_b_q     <= '0;
            ptr_out_q   <= '0;
            len_q       <= '0;
            mode_q      <= '0;
            init_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (wr_fire) begin
                case (csr_req_addr_i)
                    CsrAddrWidth'(CsrPtrA):   ptr_a_q   <= {csr_req_data_i[31:2], 2'b00};
                    CsrAddrWidth'(CsrPtrB):   ptr_b_q   <= {csr_req_data_i[31:2], 2'b00};
                    CsrAddrWidth'(CsrPtrOut): ptr_out_q <= {csr_req_data_i[31:2], 2'b00};
                    CsrAddrWidth'(CsrLen):    len_q     <= csr_req_data_i[LenWidth-1:0];
                    CsrAddrWidth'(CsrMode):   mode_q    <= csr_req_data_i[1:0];
                    CsrAddrWidth'(CsrInit):   init_q    <= csr_req_data_i;
                    default: ;
                endcase
            end
            // start needs !busy and job_done only fires while busy, so they never collide
            if (start_o) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else if (job_done_i) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (req_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= csr_req_write_i ? 32'd0 : rdata;
            end else if (csr_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign csr_rsp_valid_o = rsp_valid_q;
    assign csr_rsp_data_o  = rsp_data_q;
    assign busy_o          = busy_q;
    assign ptr_a_o         = ptr_a_q;
    assign ptr_b_o         = ptr_b_q;
    assign ptr_out_o       = ptr_out_q;
    assign len_o           = len_q;
    assign mode_o          = mode_q;
    assign init_o          = init_q;

endmodule

// File: rtl/snax_mac_stream.sv
// SNAX multiply-accumulate streaming accelerator (top level).
// Streams signed vectors A and B from TCDM and produces either a dot product or an
// element-wise product vector. Ports: clk_i/rst_ni; csr_* valid/ready CSR port;
// tcdm_req_o/tcdm_rsp_i three TCDM ports ([0] A read, [1] B read, [2] OUT write);
// done_o pulses for one cycle at job completion.
module snax_mac_stream
    import snax_mac_stream_pkg::*;
#(
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned AccWidth     = DefAccWidth,
    parameter int unsigned LenWidth     = DefLenWidth,
    parameter int unsigned CsrAddrWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CsrAddrWidth-1:0] csr_req_addr_i,
    input  logic [31:0]             csr_req_data_i,
    input  logic                    csr_req_write_i,
    input  logic                    csr_req_valid_i,
    output logic                    csr_req_ready_o,
    output logic [31:0]             csr_rsp_data_o,
    output logic                    csr_rsp_valid_o,
    input  logic                    csr_rsp_ready_i,
    output tcdm_req_t [2:0]         tcdm_req_o,
    input  tcdm_rsp_t [2:0]         tcdm_rsp_i,
    output logic                    done_o
);

    state_e                state_q, state_d;
    logic [LenWidth-1:0]   k_q, k_d;
    logic [AccWidth-1:0]   acc_q, acc_d, prod_q, prod_d, prod;
    logic [DataWidth-1:0]  a_q, a_d, b_q, b_d, op_a, op_b;
    logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic                  a_cap, b_cap, is_last, dot_write, job_done, start, busy;
    logic [31:0]           ptr_a, ptr_b, ptr_out, init, k_off;
    logic [LenWidth-1:0]   len;
    logic [1:0]            mode_raw;
    mode_e                 mode;
    logic signed [2*DataWidth-1:0] op_a_ext, op_b_ext, prod_full;
    logic                  unused_rsp;

    snax_mac_stream_csr #(
        .CsrAddrWidth (CsrAddrWidth),
        .LenWidth     (LenWidth)
    ) u_csr (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .csr_req_addr_i  (csr_req_addr_i),
        .csr_req_data_i  (csr_req_data_i),
        .csr_req_write_i (csr_req_write_i),
        .csr_req_valid_i (csr_req_valid_i),
        .csr_req_ready_o (csr_req_ready_o),
        .csr_rsp_data_o  (csr_rsp_data_o),
        .csr_rsp_valid_o (csr_rsp_valid_o),
        .csr_rsp_ready_i (csr_rsp_ready_i),
        .job_done_i      (job_done),
        .result_i        (acc_q[31:0]),
        .start_o         (start),
        .busy_o          (busy),
        .ptr_a_o         (ptr_a),
        .ptr_b_o         (ptr_b),
        .ptr_out_o       (ptr_out),
        .len_o           (len),
        .mode_o          (mode_raw),
        .init_o          (init)
    );

    // Write port responses carry nothing useful; busy is implied by the FSM state.
    assign unused_rsp = ^{tcdm_rsp_i[2].p_valid, tcdm_rsp_i[2].p.data, busy};

    assign mode      = mode_e'(mode_raw);
    assign k_off     = 32'(k_q) << 2;
    assign is_last   = (k_q == len - LenWidth'(1));
    // DOT with LEN = 0 produces no traffic; DOT_INIT still writes INIT back.
    assign dot_write = (mode == ModeDotInit) || ((mode != ModeElem) && (len != '0));

    // A response is only accepted on a port whose read has been granted and not yet captured.
    assign a_cap = ((state_q == StReq) || (state_q == StRsp)) && a_gnt_q && !a_vld_q
                   && tcdm_rsp_i[0].p_valid;
    assign b_cap = ((state_q == StReq) || (state_q == StRsp)) && b_gnt_q && !b_vld_q
                   && tcdm_rsp_i[1].p_valid;

    // Operands bypass the capture registers so the product is ready the cycle the last one lands.
    assign op_a      = a_vld_q ? a_q : tcdm_rsp_i[0].p.data[DataWidth-1:0];
    assign op_b      = b_vld_q ? b_q : tcdm_rsp_i[1].p.data[DataWidth-1:0];
    assign op_a_ext  = {{DataWidth{op_a[DataWidth-1]}}, op_a};
    assign op_b_ext  = {{DataWidth{op_b[DataWidth-1]}}, op_b};
    assign prod_full = op_a_ext * op_b_ext;
    assign prod      = prod_full[AccWidth-1:0];

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        a_d        = a_q;
        b_d        = b_q;
        a_gnt_d    = a_gnt_q;
        b_gnt_d    = b_gnt_q;
        a_vld_d    = a_vld_q;
        b_vld_d    = b_vld_q;
        done_o     = 1'b0;
        job_done   = 1'b0;
        tcdm_req_o = '0;

        if (a_cap) begin
            a_d     = tcdm_rsp_i[0].p.data[DataWidth-1:0];
            a_vld_d = 1'b1;
        end
        if (b_cap) begin
            b_d     = tcdm_rsp_i[1].p.data[DataWidth-1:0];
            b_vld_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = '0;
                    acc_d   = (mode == ModeDotInit) ? AccWidth'(init) : '0;
                    a_gnt_d = 1'b0;
                    b_gnt_d = 1'b0;
                    a_vld_d = 1'b0;
                    b_vld_d = 1'b0;
                    state_d = (len == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                tcdm_req_o[0].q_valid = !a_gnt_q;
                tcdm_req_o[0].q.addr  = ptr_a + k_off;
                tcdm_req_o[1].q_valid = !b_gnt_q;
                tcdm_req_o[1].q.addr  = ptr_b + k_off;
                if (!a_gnt_q && tcdm_rsp_i[0].q_ready) a_gnt_d = 1'b1;
                if (!b_gnt_q && tcdm_rsp_i[1].q_ready) b_gnt_d = 1'b1;
                if (a_gnt_d && b_gnt_d) state_d = StRsp;
            end
            StRsp: begin
                if ((a_vld_q || a_cap) && (b_vld_q || b_cap)) begin
                    prod_d  = prod;
                    a_gnt_d = 1'b0;
                    b_gnt_d = 1'b0;
                    a_vld_d = 1'b0;
                    b_vld_d = 1'b0;
                    if (mode == ModeElem) begin
                        state_d = StWr;
                    end else begin
                        acc_d = acc_q + prod;
                        if (is_last) begin
                            state_d = StDone;
                        end else begin
                            k_d     = k_q + LenWidth'(1);
                            state_d = StReq;
                        end
                    end
                end
            end
            StWr: begin
                tcdm_req_o[2].q_valid = 1'b1;
                tcdm_req_o[2].q.addr  = ptr_out + k_off;
                tcdm_req_o[2].q.write = 1'b1;
                tcdm_req_o[2].q.strb  = 4'hF;
                tcdm_req_o[2].q.data  = prod_q[31:0];
                if (tcdm_rsp_i[2].q_ready) begin
                    if (is_last) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + LenWidth'(1);
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                if (dot_write) begin
                    tcdm_req_o[2].q_valid = 1'b1;
                    tcdm_req_o[2].q.addr  = ptr_out;
                    tcdm_req_o[2].q.write = 1'b1;
                    tcdm_req_o[2].q.strb  = 4'hF;
                    tcdm_req_o[2].q.data  = acc_q[31:0];
                end
                if (!dot_write || tcdm_rsp_i[2].q_ready) begin
                    done_o   = 1'b1;
                    job_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
        end
    end

endmodule

// File: tb/tb_snax_mac_stream.sv
// Directed bench for snax_mac_stream with a reactive TCDM memory model and a write
// scoreboard: expected OUT writes are queued before each start and popped as the
// DUT's write port is granted.
module tb_snax_mac_stream;
    import snax_mac_stream_pkg::*;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [3:0]      csr_addr = '0;
    logic [31:0]     csr_wdata = '0;
    logic            csr_write = 1'b0;
    logic            csr_valid = 1'b0;
    logic            csr_rsp_ready = 1'b0;
    logic            csr_ready, csr_rsp_valid, done;
    logic [31:0]     csr_rdata;
    tcdm_req_t [2:0] req;
    tcdm_rsp_t [2:0] rsp;

    always #5 clk = ~clk;

    snax_mac_stream dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .csr_req_addr_i  (csr_addr),
        .csr_req_data_i  (csr_wdata),
        .csr_req_write_i (csr_write),
        .csr_req_valid_i (csr_valid),
        .csr_req_ready_o (csr_ready),
        .csr_rsp_data_o  (csr_rdata),
        .csr_rsp_valid_o (csr_rsp_valid),
        .csr_rsp_ready_i (csr_rsp_ready),
        .tcdm_req_o      (req),
        .tcdm_rsp_i      (rsp),
        .done_o          (done)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [0:1023];
    logic [63:0] exp_q [$];
    bit          stall_en = 1'b0;
    int          done_cnt = 0;
    int          qv_cnt = 0;
    int          gnt_cnt0 = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (req[0].q_valid || req[1].q_valid || req[2].q_valid) qv_cnt <= qv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // TCDM model: reads answer 1..3 cycles after grant, grants may stall when stall_en.
    initial begin : tcdm_model
        int          cnt [2];
        logic [31:0] raddr [2];
        logic        pv [3];
        logic        gr [3];
        logic [31:0] paddr [3];
        logic [31:0] pdata [3];
        logic [63:0] e;
        for (int p = 0; p < 3; p++) begin
            pv[p] = 1'b0;
            gr[p] = 1'b0;
            paddr[p] = '0;
            pdata[p] = '0;
        end
        cnt[0] = 0;
        cnt[1] = 0;
        rsp = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (pv[p] && !gr[p] && req[p].q_valid) begin
                    check($sformatf("stable_addr%0d", p), req[p].q.addr, paddr[p]);
                    if (p == 2) check("stable_data2", req[2].q.data, pdata[2]);
                end
                pv[p] = req[p].q_valid;
                paddr[p] = req[p].q.addr;
                pdata[p] = req[p].q.data;
                gr[p] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                rsp[p].p_valid = 1'b0;
                if (cnt[p] > 0) begin
                    cnt[p]--;
                    if (cnt[p] == 0) begin
                        rsp[p].p_valid = 1'b1;
                        rsp[p].p.data = mem[raddr[p][11:2]];
                    end
                end
                rsp[p].q_ready = 1'b0;
                if (req[p].q_valid && cnt[p] == 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
                    rsp[p].q_ready = 1'b1;
                    gr[p] = 1'b1;
                    raddr[p] = req[p].q.addr;
                    cnt[p] = stall_en ? int'($urandom_range(1, 3)) : 1;
                    if (p == 0) gnt_cnt0++;
                end
            end
            rsp[2].q_ready = 1'b0;
            rsp[2].p_valid = 1'b0;
            if (req[2].q_valid && (!stall_en || $urandom_range(0, 2) != 0)) begin
                rsp[2].q_ready = 1'b1;
                gr[2] = 1'b1;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", req[2].q.addr, e[63:32]);
                    check("wr_data", req[2].q.data, e[31:0]);
                    check("wr_ctl", {27'd0, req[2].q.write, req[2].q.strb}, 32'h1F);
                end
            end
        end
    end

    task automatic csr_issue(input logic [3:0] a, input logic [31:0] d, input logic w);
        int n = 0;
        @(negedge clk);
        csr_addr = a;
        csr_wdata = d;
        csr_write = w;
        csr_valid = 1'b1;
        while (!csr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!csr_ready) check("csr_accept_timeout", 32'(csr_ready), 32'd1);
        @(posedge clk);
        #1 csr_valid = 1'b0;
    endtask

    task automatic csr_finish(output logic [31:0] rd);
        int n = 0;
        while (!csr_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!csr_rsp_valid) check("csr_rsp_timeout", 32'(csr_rsp_valid), 32'd1);
        rd = csr_rdata;
        csr_rsp_ready = 1'b1;
        @(posedge clk);
        #1 csr_rsp_ready = 1'b0;
    endtask

    task automatic csr_wr(input int a, input logic [31:0] d);
        logic [31:0] rd;
        csr_issue(4'(a), d, 1'b1);
        csr_finish(rd);
    endtask

    task automatic csr_rd(input int a, output logic [31:0] rd);
        csr_issue(4'(a), 32'd0, 1'b0);
        csr_finish(rd);
    endtask

    task automatic setup(input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] po,
                         input int len, input int mode, input logic [31:0] init);
        csr_wr(CsrPtrA, pa);
        csr_wr(CsrPtrB, pb);
        csr_wr(CsrPtrOut, po);
        csr_wr(CsrLen, 32'(len));
        csr_wr(CsrMode, 32'(mode));
        csr_wr(CsrInit, init);
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic run(input string tag);
        int d0;
        d0 = done_cnt;
        csr_wr(CsrCtrl, 32'd1);
        wait_done(d0);
        repeat (5) @(negedge clk);
        check({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic [31:0] rd;
        int          d0, q0, n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[(32'h100 >> 2) + i] = 32'(i + 1);
            mem[(32'h200 >> 2) + i] = 32'(i + 5);
        end
        mem[32'h500 >> 2] = -32'sd2;
        mem[(32'h500 >> 2) + 1] = 32'd3;
        mem[(32'h500 >> 2) + 2] = 32'h7FFF_FFFF;
        mem[32'h600 >> 2] = 32'd4;
        mem[(32'h600 >> 2) + 1] = -32'sd5;
        mem[(32'h600 >> 2) + 2] = 32'd2;
        for (int i = 0; i < 2; i++) begin
            mem[(32'h800 >> 2) + i] = 32'd1;
            mem[(32'h900 >> 2) + i] = 32'd1;
        end
        for (int i = 0; i < 8; i++) begin
            mem[(32'hC00 >> 2) + i] = 32'(i + 1);
            mem[(32'hD00 >> 2) + i] = 32'(i + 1);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_qv", {29'd0, req[2].q_valid, req[1].q_valid, req[0].q_valid}, 32'd0);
        check("rst_req_ready", 32'(csr_ready), 32'd1);
        check("rst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_ni = 1'b1;
        csr_rd(CsrStatus, rd);
        check("rst_status", rd, 32'd0);
        csr_rd(CsrLen, rd);
        check("rst_len", rd, 32'd0);

        // DOT, LEN = 4 -> 70; PTR_A low bits ignored
        setup(32'h103, 32'h200, 32'h300, 4, 0, 32'd0);
        csr_rd(CsrPtrA, rd);
        check("ptr_a_mask", rd, 32'h100);
        exp_q.push_back({32'h300, 32'd70});
        d0 = done_cnt;
        csr_issue(4'(CsrCtrl), 32'd1, 1'b1);
        @(negedge clk);
        check("dot_req_t1", 32'(req[0].q_valid), 32'd1);
        check("dot_req_addr", req[0].q.addr, 32'h100);
        csr_finish(rd);
        wait_done(d0);
        repeat (5) @(negedge clk);
        check("dot_pulses", 32'(done_cnt - d0), 32'd1);
        check("dot_sb_empty", 32'(exp_q.size()), 32'd0);
        csr_rd(CsrResult, rd);
        check("dot_result", rd, 32'd70);
        csr_rd(CsrStatus, rd);
        check("dot_status", rd, 32'd2);

        // ELEM, LEN = 3
        setup(32'h500, 32'h600, 32'h700, 3, 1, 32'd0);
        exp_q.push_back({32'h700, 32'hFFFF_FFF8});
        exp_q.push_back({32'h704, 32'hFFFF_FFF1});
        exp_q.push_back({32'h708, 32'hFFFF_FFFE});
        run("elem");

        // DOT_INIT with stalls and response skew
        setup(32'h800, 32'h900, 32'hA00, 2, 2, 32'd100);
        stall_en = 1'b1;
        exp_q.push_back({32'hA00, 32'd102});
        run("dinit");
        stall_en = 1'b0;
        csr_rd(CsrResult, rd);
        check("dinit_result", rd, 32'd102);

        // LEN = 0 DOT: done the cycle after start, no traffic
        setup(32'h100, 32'h200, 32'hB00, 0, 0, 32'd0);
        d0 = done_cnt;
        q0 = qv_cnt;
        csr_issue(4'(CsrCtrl), 32'd1, 1'b1);
        @(negedge clk);
        check("len0_done_t1", 32'(done), 32'd1);
        csr_finish(rd);
        repeat (4) @(negedge clk);
        check("len0_no_traffic", 32'(qv_cnt - q0), 32'd0);
        check("len0_pulses", 32'(done_cnt - d0), 32'd1);

        // DOT_INIT LEN = 0 still writes INIT
        setup(32'h100, 32'h200, 32'hB04, 0, 2, 32'd55);
        exp_q.push_back({32'hB04, 32'd55});
        run("dinit0");

        // Start and LEN write during a busy LEN = 8 job are ignored
        setup(32'hC00, 32'hD00, 32'hE00, 8, 0, 32'd0);
        exp_q.push_back({32'hE00, 32'd204});
        d0 = done_cnt;
        csr_wr(CsrCtrl, 32'd1);
        csr_wr(CsrCtrl, 32'd1);
        csr_wr(CsrLen, 32'd2);
        wait_done(d0);
        repeat (40) @(negedge clk);
        check("busy_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_sb_empty", 32'(exp_q.size()), 32'd0);
        csr_rd(CsrResult, rd);
        check("busy_result", rd, 32'd204);
        csr_rd(CsrLen, rd);
        check("busy_len_kept", rd, 32'd8);

        // CSR response back-pressure, unmapped read
        csr_wr(CsrPtrB, 32'h1237);
        csr_issue(4'(CsrPtrB), 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(csr_ready), 32'd0);
            check("bp_rsp_valid", 32'(csr_rsp_valid), 32'd1);
            check("bp_rsp_data", csr_rdata, 32'h1234);
        end
        csr_finish(rd);
        csr_rd(15, rd);
        check("unmapped_rd", rd, 32'd0);

        // Reset while an element is in RSP
        setup(32'h100, 32'h200, 32'hF00, 4, 0, 32'd0);
        q0 = gnt_cnt0;
        csr_wr(CsrCtrl, 32'd1);
        n = 0;
        while (gnt_cnt0 < q0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (gnt_cnt0 < q0 + 2) check("rst_grant_timeout", 32'(gnt_cnt0), 32'(q0 + 2));
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_qv", {29'd0, req[2].q_valid, req[1].q_valid, req[0].q_valid}, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(csr_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        csr_rd(CsrPtrA, rd);
        check("post_rst_ptr_a", rd, 32'd0);
        csr_rd(CsrStatus, rd);
        check("post_rst_status", rd, 32'd0);
        setup(32'h100, 32'h200, 32'hF00, 4, 0, 32'd0);
        exp_q.push_back({32'hF00, 32'd70});
        run("post_rst");
        csr_rd(CsrResult, rd);
        check("post_rst_result", rd, 32'd70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snax_mac_stream.md
# snax_mac_stream

Native SNAX multiply-accumulate accelerator, the successor to the HWPE-wrapped MAC. It drops the HWPE controller and engine and talks to the Snitch core directly through a CSR valid/ready port. It streams signed operand vectors A and B from TCDM and computes either a dot product or an element-wise product vector, writing results back through a dedicated TCDM write port. It sits beside the core in the SNAX cluster in the same position as the HWPE MAC, on three TCDM ports.

## Interface
- DataWidth, 32: element and TCDM word width in bits; 32 only.
- AccWidth, 32: accumulator width in bits; must be ≥ DataWidth.
- LenWidth, 16: width of the LEN register.
- CsrAddrWidth, 4: CSR address width.
- tcdm_req_t, logic: TCDM request type with fields q_valid, q.addr, q.write, q.data, q.strb.
- tcdm_rsp_t, logic: TCDM response type with fields q_ready, p_valid, p.data.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- csr_req_addr_i  in  CsrAddrWidth  CSR address.
- csr_req_data_i  in  32  CSR write data.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request accepted.
- csr_rsp_data_o  out  32  read data; 0 for writes.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response consumed.
- tcdm_req_o  out  3 × tcdm_req_t  TCDM requests; [0]=A read, [1]=B read, [2]=OUT write.
- tcdm_rsp_i  in  3 × tcdm_rsp_t  TCDM responses, same order.
- done_o  out  1  one-cycle pulse when a job completes.

## Operation
CSR map:
- 0 PTR_A, 1 PTR_B, 2 PTR_OUT: byte addresses; bits [1:0] are ignored and read as 0.
- 3 LEN: element count.
- 4 MODE: 0 = DOT, 1 = ELEM, 2 = DOT_INIT.
- 5 INIT: initial accumulator value for DOT_INIT.
- 6 CTRL: write bit0 = 1 to start.
- 7 STATUS: bit0 busy, bit1 done. Read-only.
- 8 RESULT: accumulator, low 32 bits.
- Unmapped addresses read 0; writes to them are dropped.

CSR handshake:
- csr_req_ready_o = !csr_rsp_valid_o.
- The response is registered and is presented the cycle after acceptance.
- The response is held until csr_rsp_ready_i.

Busy rules:
- While busy, writes to addresses 0–6 are acknowledged but ignored.
- done is sticky; it is cleared by the next accepted start.

FSM states: IDLE, REQ, RSP, WR, DONE.
- IDLE → start: load the address counters and element counter k = 0. Accumulator = INIT in DOT_INIT mode, otherwise 0. If LEN = 0, go to DONE. Otherwise go to REQ.
- REQ: assert q_valid on ports 0 and 1 with addr = PTR + 4k and write = 0. Each port drops its request independently once q_ready is seen. Go to RSP when both requests are granted.
- RSP: capture each p.data when its p_valid arrives; the two ports may return in any cycle order. When both are captured, compute the product.
  - DOT / DOT_INIT: acc += product. Then go to REQ, or to DONE if k = LEN − 1.
  - ELEM: go to WR.
- WR: assert port 2 with addr = PTR_OUT + 4k, write = 1, strb = 4'hF, data = product. On q_ready, go to REQ, or to DONE if k = LEN − 1. Any p_valid on port 2 is ignored.
- DONE: for DOT modes, write acc to PTR_OUT on port 2 and wait for q_ready; ELEM skips this. Then assert done_o for one cycle, set done, clear busy, and return to IDLE.

Arithmetic:
- Operands are signed DataWidth values.
- The product is the full 2·DataWidth result truncated to AccWidth.
- The accumulator wraps modulo 2^AccWidth.
- The written value is the low 32 bits of the result.
- Addresses wrap modulo 2^32.

## Timing
Reset values:
- All q_valid = 0; csr_req_ready_o = 1.
- csr_rsp_valid_o = 0; done_o = 0.
- All CSRs = 0; state = IDLE.

Latency and handshake:
- Start is accepted at cycle t; REQ asserts at t+1.
- With zero-wait TCDM, each element takes REQ 1 cycle + RSP ≥1 cycle (+ WR 1 cycle in ELEM).
- q_valid and its payload stay stable until q_ready.
- At most one outstanding read per port.
- Start with LEN = 0: done_o at t+1, with no TCDM traffic in DOT/ELEM. DOT_INIT with LEN = 0 still writes INIT to PTR_OUT.
- A start written while busy is ignored.
- Reset mid-job: everything returns to reset values immediately and asynchronously. Outstanding responses arriving after reset are ignored.

## Structure
- Package snax_mac_stream_pkg holds:
  - CSR address localparams;
  - mode_e and state_e enums;
  - the default values of DataWidth, AccWidth and LenWidth.
- Sub-module snax_mac_stream_csr contains the CSR register file, the response register and the busy/done/start logic.
- The top level contains the FSM, counters, datapath and TCDM driving.

## Test plan
- DOT, LEN = 4, A = {1, 2, 3, 4}, B = {5, 6, 7, 8}, zero-wait TCDM → word 70 at PTR_OUT; RESULT = 70; one done_o pulse.
- ELEM, LEN = 3, A = {−2, 3, 0x7FFFFFFF}, B = {4, −5, 2} → OUT = {−8, −15, 0xFFFFFFFE}.
- DOT_INIT with INIT = 100, LEN = 2, A = {1, 1}, B = {1, 1}, with random q_ready stalls and p_valid skew between ports 0 and 1 → result 102, and request payloads stay stable while stalled.
- LEN = 0 in DOT → done_o the cycle after start, no q_valid asserted; a CTRL start issued during a busy LEN = 8 job is ignored (result matches a single job).
- CSR back-pressure: hold csr_rsp_ready_i = 0 for 5 cycles → csr_req_ready_o stays 0 and the response data stays stable; a read of unmapped address 15 returns 0.
- Assert rst_ni low in the middle of an element in RSP → all q_valid = 0 the same cycle; a new job after reset computes the correct result.
